// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

    // Tuse value meaning "operand never read"
    localparam logic [1:0] TUSE_NEVER = 2'd3;

    // md_type encodings
    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    // Default multiply/divide busy lengths
    localparam int unsigned DEF_MULT_CYC = 5;
    localparam int unsigned DEF_DIV_CYC  = 10;

    // $zero is hard-wired, so it never carries a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One source/destination pair: stall when the D instruction needs the value
    // before the producing stage can supply it.
    function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] a3, input logic [1:0] tnew);
        return (src != REG_ZERO) && (src == a3) && (tuse != TUSE_NEVER) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy counter for the multi-cycle multiply/divide unit.
module md_busy_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = DEF_MULT_CYC,
    parameter int unsigned DIV_CYC  = DEF_DIV_CYC,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_type,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load on an idle start, otherwise count down; a start while busy is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == '0) begin
            if (md_start) begin
                cnt_d = (md_type == MD_MULT) ? MULT_LOAD : DIV_LOAD;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection, stall generation and stall-cycle counter for the 5-stage core.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = DEF_MULT_CYC,
    parameter int unsigned DIV_CYC  = DEF_DIV_CYC,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        md_start,
    input  logic        md_type,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic        stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_type  (md_type),
        .md_busy  (md_busy)
    );

    // Zero-latency stall decision from the D/E/M fields and the MD unit state.
    always_comb begin
        stall = reg_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew)
              | reg_hazard(D_rs, D_Tuse_rs, M_A3, M_Tnew)
              | reg_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew)
              | reg_hazard(D_rt, D_Tuse_rt, M_A3, M_Tnew)
              | (D_is_md & (md_start | md_busy));
    end

    // Pipeline control; reset keeps the front end running with no bubble.
    always_comb begin
        pc_en  = ~stall;
        fd_en  = ~stall;
        de_clr = stall;
        if (reset) begin
            pc_en  = 1'b1;
            fd_en  = 1'b1;
            de_clr = 1'b0;
        end
    end

    // Stall counter next state; wraps naturally at 32 bits.
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall);
    end

    // Stall counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
